// File: rtl/fft_pair_feeder.sv
// fft_pair_feeder: pairs a serial stream of complex IEEE-754 single samples
// into radix-2 butterfly operands (a, b), pulses launch per pair, and delays
// a valid/last tag by BF_LATENCY so butterfly results can be captured.
//
// Build option: define FFT_FEEDER_FLUSH_PAD_EN to complete a dangling odd
// sample on flush with a (A, +0.0) padded pair. Without it, a flush while a
// lone sample is held simply discards that sample.
module fft_pair_feeder #(
    parameter int BF_LATENCY  = 2,
    parameter int FRAME_PAIRS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_re,
    input  logic [31:0] s_img,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        flush,
    input  logic        hold,
    output logic [31:0] a_re,
    output logic [31:0] a_img,
    output logic [31:0] b_re,
    output logic [31:0] b_img,
    output logic        launch,
    output logic        res_valid,
    output logic        res_last,
    output logic [15:0] pair_idx
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_PAD   = 2'd2;

    localparam logic [15:0] LAST_IDX = 16'(FRAME_PAIRS - 1);

    logic [1:0]  state;
    logic [31:0] hold_re;
    logic [31:0] hold_img;
    logic [15:0] frame_cnt;
    logic        launch_last;

    logic        xfer;       // sample handshake completes this cycle
    logic        pair_go;    // real pair (held A + incoming B) issues this cycle
    logic        pad_go;     // padded pair issues this cycle
    logic        issue;      // any pair issues this cycle
    logic        cnt_wrap;   // current pair is the last of the frame
    logic        flush_done; // the issuing pair closes a flushed frame
    logic        cnt_clr;    // flush clears the counter with no pair issuing

    // s_ready deliberately ignores s_valid; low in reset, hold, and PAD
    assign s_ready  = rst_n && !hold && (state != ST_PAD);
    assign xfer     = s_valid && s_ready;
    assign pair_go  = (state == ST_HALF) && xfer;
    assign cnt_wrap = (frame_cnt == LAST_IDX);

`ifdef FFT_FEEDER_FLUSH_PAD_EN
    assign pad_go     = (state == ST_PAD);
    // In HALF the flush is deferred to the PAD launch, which needs the count
    assign cnt_clr    = flush && (state != ST_HALF);
`else
    assign pad_go     = 1'b0;
    assign cnt_clr    = flush;
`endif

    assign issue      = pair_go || pad_go;
    assign flush_done = pad_go || (pair_go && flush);

    // Pairing state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (xfer) state <= ST_HALF;
                end
                ST_HALF: begin
                    if (xfer) begin
                        state <= ST_EMPTY;
                    end else if (flush) begin
`ifdef FFT_FEEDER_FLUSH_PAD_EN
                        state <= ST_PAD;
`else
                        state <= ST_EMPTY;
`endif
                    end
                end
                ST_PAD:  state <= ST_EMPTY;
                default: state <= ST_EMPTY;
            endcase
        end
    end

    // A holding register: captures the first sample of each pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_re  <= '0;
            hold_img <= '0;
        end else if ((state == ST_EMPTY) && xfer) begin
            hold_re  <= s_re;
            hold_img <= s_img;
        end
    end

    // Operand registers: change only when a pair issues, stable otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_re  <= '0;
            a_img <= '0;
            b_re  <= '0;
            b_img <= '0;
        end else if (pair_go) begin
            a_re  <= hold_re;
            a_img <= hold_img;
            b_re  <= s_re;
            b_img <= s_img;
        end else if (pad_go) begin
            a_re  <= hold_re;
            a_img <= hold_img;
            b_re  <= 32'h0000_0000;
            b_img <= 32'h0000_0000;
        end
    end

    // Launch pulse, its last tag, and the index of the launched pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            launch      <= 1'b0;
            launch_last <= 1'b0;
            pair_idx    <= '0;
        end else begin
            launch      <= issue;
            launch_last <= issue && (cnt_wrap || flush_done);
            if (issue) pair_idx <= frame_cnt;
        end
    end

    // Frame counter: next pair index; wraps at frame end, clears on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (issue) begin
            if (flush || pad_go || cnt_wrap) frame_cnt <= '0;
            else                             frame_cnt <= frame_cnt + 16'd1;
        end else if (cnt_clr) begin
            frame_cnt <= '0;
        end
    end

    // Valid/last delay line matching butterfly latency; ignores hold
    logic [BF_LATENCY-1:0] vld_pipe;
    logic [BF_LATENCY-1:0] lst_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            lst_pipe <= '0;
        end else begin
            vld_pipe[0] <= launch;
            lst_pipe[0] <= launch_last;
            for (int i = 1; i < BF_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                lst_pipe[i] <= lst_pipe[i-1];
            end
        end
    end

    assign res_valid = vld_pipe[BF_LATENCY-1];
    assign res_last  = lst_pipe[BF_LATENCY-1];

endmodule

// File: tb/tb_fft_pair_feeder.sv
// Directed self-checking bench for fft_pair_feeder (BF_LATENCY=2,
// FRAME_PAIRS=4). Inputs are driven and outputs sampled 1 time unit after
// each rising edge. The flush-with-odd-sample step follows whichever build
// option FFT_FEEDER_FLUSH_PAD_EN selects.
module tb_fft_pair_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_re, s_img;
    logic        s_valid, s_ready;
    logic        flush, hold;
    logic [31:0] a_re, a_img, b_re, b_img;
    logic        launch, res_valid, res_last;
    logic [15:0] pair_idx;

    int tests = 0;
    int fails = 0;

    fft_pair_feeder #(.BF_LATENCY(2), .FRAME_PAIRS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_re(s_re), .s_img(s_img), .s_valid(s_valid), .s_ready(s_ready),
        .flush(flush), .hold(hold),
        .a_re(a_re), .a_img(a_img), .b_re(b_re), .b_img(b_img),
        .launch(launch), .res_valid(res_valid), .res_last(res_last),
        .pair_idx(pair_idx)
    );

    always #5 clk = ~clk;

    // advance one cycle and land just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; s_re = '0; s_img = '0; s_valid = 1'b0; flush = 1'b0; hold = 1'b0;

        // ---- reset state
        #12;
        chk1 ("rst_s_ready", s_ready, 1'b0);
        chk1 ("rst_launch", launch, 1'b0);
        chk1 ("rst_res_valid", res_valid, 1'b0);
        chk1 ("rst_res_last", res_last, 1'b0);
        chk32("rst_a_re", a_re, 32'h0);
        chk32("rst_b_img", b_img, 32'h0);
        chk32("rst_pair_idx", {16'h0, pair_idx}, 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk1 ("rel_s_ready", s_ready, 1'b1);

        // ---- basic pair: 1.0+2.0j then -1.0+3.0j
        s_valid = 1'b1; s_re = 32'h3F800000; s_img = 32'h40000000;
        step();
        chk1 ("t1_no_launch_first", launch, 1'b0);
        s_re = 32'hBF800000; s_img = 32'h40400000;
        step();
        s_valid = 1'b0;
        chk1 ("t1_launch", launch, 1'b1);
        chk32("t1_a_re", a_re, 32'h3F800000);
        chk32("t1_a_img", a_img, 32'h40000000);
        chk32("t1_b_re", b_re, 32'hBF800000);
        chk32("t1_b_img", b_img, 32'h40400000);
        chk32("t1_idx", {16'h0, pair_idx}, 32'd0);
        step();
        chk1 ("t1_launch_pulse", launch, 1'b0);
        chk1 ("t1_res_early", res_valid, 1'b0);
        step();
        chk1 ("t1_res_valid", res_valid, 1'b1);
        chk1 ("t1_res_last", res_last, 1'b0);
        chk32("t1_a_stable", a_re, 32'h3F800000);

        // ---- flush in EMPTY: no launch, counter cleared
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk1 ("fe_no_launch", launch, 1'b0);
        chk1 ("fe_s_ready", s_ready, 1'b1);

        // ---- 8 continuous samples, one full frame
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_re = 32'(i + 1); s_img = 32'(i + 101);
            step();
            if (i % 2 == 1) begin
                chk1 ("t2_launch", launch, 1'b1);
                chk32("t2_idx", {16'h0, pair_idx}, 32'(i / 2));
                chk32("t2_a_re", a_re, 32'(i));
                chk32("t2_b_re", b_re, 32'(i + 1));
                chk32("t2_b_img", b_img, 32'(i + 101));
            end else begin
                chk1 ("t2_no_launch", launch, 1'b0);
            end
            if (i >= 3 && i % 2 == 1) begin
                chk1 ("t2_res_valid", res_valid, 1'b1);
                chk1 ("t2_res_last_mid", res_last, 1'b0);
            end
        end
        s_valid = 1'b0;
        step();
        chk1 ("t2_idle", launch, 1'b0);
        step();
        chk1 ("t2_res_valid_4th", res_valid, 1'b1);
        chk1 ("t2_res_last_4th", res_last, 1'b1);
        // next frame restarts at index 0
        s_valid = 1'b1; s_re = 32'd20;
        step();
        s_re = 32'd21;
        step();
        s_valid = 1'b0;
        chk1 ("t2_nf_launch", launch, 1'b1);
        chk32("t2_nf_idx", {16'h0, pair_idx}, 32'd0);
        chk32("t2_nf_a", a_re, 32'd20);

        // ---- hold for 5 cycles with a result pending
        s_valid = 1'b1; s_re = 32'd30;
        step();
        s_re = 32'd31;
        step();
        chk1 ("th_launch", launch, 1'b1);
        chk32("th_idx", {16'h0, pair_idx}, 32'd1);
        hold = 1'b1; s_re = 32'd40;
        #1;
        chk1 ("th_s_ready", s_ready, 1'b0);
        for (int h = 1; h <= 5; h++) begin
            step();
            chk1 ("th_no_launch", launch, 1'b0);
            chk32("th_a_stable", a_re, 32'd30);
            chk32("th_b_stable", b_re, 32'd31);
            if (h == 2) chk1("th_res_valid", res_valid, 1'b1);
        end
        hold = 1'b0; s_valid = 1'b0;

        // ---- three samples then flush
        flush = 1'b1;
        step();
        flush = 1'b0;
        s_valid = 1'b1; s_re = 32'd50;
        step();
        s_re = 32'd51;
        step();
        chk1 ("tf_launch1", launch, 1'b1);
        chk32("tf_idx1", {16'h0, pair_idx}, 32'd0);
        chk32("tf_a1", a_re, 32'd50);
        s_re = 32'd52; s_img = 32'd152;
        step();
        chk1 ("tf_odd_no_launch", launch, 1'b0);
        s_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
`ifdef FFT_FEEDER_FLUSH_PAD_EN
        chk1 ("tf_pad_s_ready", s_ready, 1'b0);
        chk1 ("tf_pad_pre_launch", launch, 1'b0);
        step();
        chk1 ("tf_pad_launch", launch, 1'b1);
        chk32("tf_pad_a_re", a_re, 32'd52);
        chk32("tf_pad_a_img", a_img, 32'd152);
        chk32("tf_pad_b_re", b_re, 32'h0);
        chk32("tf_pad_b_img", b_img, 32'h0);
        chk32("tf_pad_idx", {16'h0, pair_idx}, 32'd1);
        chk1 ("tf_pad_ready_back", s_ready, 1'b1);
        step();
        step();
        chk1 ("tf_pad_res_valid", res_valid, 1'b1);
        chk1 ("tf_pad_res_last", res_last, 1'b1);
`else
        chk1 ("tf_nopad_s_ready", s_ready, 1'b1);
        chk1 ("tf_nopad_no_launch", launch, 1'b0);
        s_valid = 1'b1; s_re = 32'd60;
        step();
        chk1 ("tf_nopad_no_launch2", launch, 1'b0);
        s_re = 32'd61;
        step();
        s_valid = 1'b0;
        chk1 ("tf_nopad_launch", launch, 1'b1);
        chk32("tf_nopad_a", a_re, 32'd60);
        chk32("tf_nopad_b", b_re, 32'd61);
        chk32("tf_nopad_idx", {16'h0, pair_idx}, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
`endif

        // ---- flush coincident with completing transfer
        s_valid = 1'b1; s_re = 32'd70;
        step();
        s_re = 32'd71; flush = 1'b1;
        step();
        flush = 1'b0; s_valid = 1'b0;
        chk1 ("tc_launch", launch, 1'b1);
        chk32("tc_idx", {16'h0, pair_idx}, 32'd0);
        chk32("tc_a", a_re, 32'd70);
        chk32("tc_b", b_re, 32'd71);
        chk1 ("tc_no_pad_ready", s_ready, 1'b1);
        step();
        chk1 ("tc_single_launch", launch, 1'b0);
        chk1 ("tc_ready_after", s_ready, 1'b1);
        step();
        chk1 ("tc_res_valid", res_valid, 1'b1);
        chk1 ("tc_res_last", res_last, 1'b1);

        // ---- reset mid-operation: sample held, launch in flight
        s_valid = 1'b1; s_re = 32'd80;
        step();
        s_re = 32'd81;
        step();
        chk1 ("tr_launch", launch, 1'b1);
        s_re = 32'd82;
        step();
        chk1 ("tr_inflight", res_valid, 1'b0);
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk32("tr_a_re", a_re, 32'h0);
        chk32("tr_b_re", b_re, 32'h0);
        chk1 ("tr_launch0", launch, 1'b0);
        chk1 ("tr_res0", res_valid, 1'b0);
        chk1 ("tr_ready0", s_ready, 1'b0);
        chk32("tr_idx0", {16'h0, pair_idx}, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk1 ("tr_no_res", res_valid, 1'b0);
        end
        s_valid = 1'b1; s_re = 32'd90;
        step();
        chk1 ("tr_first_no_launch", launch, 1'b0);
        s_re = 32'd91;
        step();
        s_valid = 1'b0;
        chk1 ("tr_new_launch", launch, 1'b1);
        chk32("tr_new_a", a_re, 32'd90);
        chk32("tr_new_b", b_re, 32'd91);
        chk32("tr_new_idx", {16'h0, pair_idx}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
